// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath.
interface multicycle_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memready;
    logic       pcen;
    logic       irwrite;
    logic       iord;
    logic       memwrite;
    logic       byte_enable;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [3:0] alucontrol;
    logic       res_zeroextimm;
    logic [3:0] state;

    // Controller side: decodes instruction fields, drives all selects and strobes.
    modport master (
        input  op, funct, zero, memready,
        output pcen, irwrite, iord, memwrite, byte_enable, regwrite, regdst,
               memtoreg, alusrca, alusrcb, pcsrc, alucontrol, res_zeroextimm, state
    );

    // Datapath side.
    modport slave (
        output op, funct, zero, memready,
        input  pcen, irwrite, iord, memwrite, byte_enable, regwrite, regdst,
               memtoreg, alusrca, alusrcb, pcsrc, alucontrol, res_zeroextimm, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle MIPS datapath with a shared ALU and a
// unified memory port that completes accesses on a memready handshake.
module multicycle_controller (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master ctrl
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_LB   = 6'b100000;
    localparam logic [5:0] OP_SB   = 6'b101000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_NOR = 6'b100111;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_BNEEX   = 4'd9,
        S_IMMEX   = 4'd10,
        S_IMMWB   = 4'd11,
        S_JEX     = 4'd12
    } state_e;

    state_e     state_q;
    logic [5:0] op_q;
    logic [5:0] funct_q;

    logic pcwrite;
    logic branch_eq;
    logic branch_ne;
    logic irwrite_raw;
    logic regwrite_raw;
    logic memwrite_raw;

    // True for the R-type function codes this datapath implements.
    function automatic logic funct_legal(input logic [5:0] f);
        case (f)
            F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_NOR: funct_legal = 1'b1;
            default:                                funct_legal = 1'b0;
        endcase
    endfunction

    // ALU operation for an R-type function code.
    function automatic logic [3:0] funct_alu(input logic [5:0] f);
        case (f)
            F_SUB:   funct_alu = ALU_SUB;
            F_AND:   funct_alu = ALU_AND;
            F_OR:    funct_alu = ALU_OR;
            F_SLT:   funct_alu = ALU_SLT;
            F_NOR:   funct_alu = ALU_NOR;
            default: funct_alu = ALU_ADD;
        endcase
    endfunction

    // State sequencing; op/funct are captured on DECODE exit so later fetch-side changes cannot leak in.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= 6'd0;
            funct_q <= 6'd0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (ctrl.memready) state_q <= S_DECODE;
                end
                S_DECODE: begin
                    op_q    <= ctrl.op;
                    funct_q <= ctrl.funct;
                    case (ctrl.op)
                        OP_LW, OP_LB, OP_SW, OP_SB: state_q <= S_MEMADR;
                        OP_R:    state_q <= funct_legal(ctrl.funct) ? S_RTYPEEX : S_FETCH;
                        OP_BEQ:  state_q <= S_BEQEX;
                        OP_BNE:  state_q <= S_BNEEX;
                        OP_ADDI, OP_ANDI, OP_ORI: state_q <= S_IMMEX;
                        OP_J:    state_q <= S_JEX;
                        default: state_q <= S_FETCH;
                    endcase
                end
                S_MEMADR: begin
                    state_q <= (op_q == OP_LW || op_q == OP_LB) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    if (ctrl.memready) state_q <= S_MEMWB;
                end
                S_MEMWR: begin
                    if (ctrl.memready) state_q <= S_FETCH;
                end
                S_RTYPEEX: state_q <= S_RTYPEWB;
                S_IMMEX:   state_q <= S_IMMWB;
                default:   state_q <= S_FETCH;
            endcase
        end
    end

    // Moore output decode from the current state and latched fields; strobes are gated by reset.
    always_comb begin
        pcwrite             = 1'b0;
        branch_eq           = 1'b0;
        branch_ne           = 1'b0;
        irwrite_raw         = 1'b0;
        regwrite_raw        = 1'b0;
        memwrite_raw        = 1'b0;
        ctrl.iord           = 1'b0;
        ctrl.byte_enable    = 1'b0;
        ctrl.regdst         = 1'b0;
        ctrl.memtoreg       = 1'b0;
        ctrl.alusrca        = 1'b0;
        ctrl.alusrcb        = 2'b00;
        ctrl.pcsrc          = 2'b00;
        ctrl.alucontrol     = ALU_ADD;
        ctrl.res_zeroextimm = 1'b0;
        case (state_q)
            S_FETCH: begin
                ctrl.alusrcb = 2'b01;
                irwrite_raw  = ctrl.memready;
                pcwrite      = ctrl.memready;
            end
            S_DECODE: begin
                ctrl.alusrcb = 2'b11;
            end
            S_MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b10;
            end
            S_MEMRD: begin
                ctrl.iord        = 1'b1;
                ctrl.byte_enable = (op_q == OP_LB);
            end
            S_MEMWB: begin
                ctrl.memtoreg    = 1'b1;
                regwrite_raw     = 1'b1;
                ctrl.byte_enable = (op_q == OP_LB);
            end
            S_MEMWR: begin
                ctrl.iord        = 1'b1;
                memwrite_raw     = 1'b1;
                ctrl.byte_enable = (op_q == OP_SB);
            end
            S_RTYPEEX: begin
                ctrl.alusrca    = 1'b1;
                ctrl.alucontrol = funct_alu(funct_q);
            end
            S_RTYPEWB: begin
                ctrl.regdst  = 1'b1;
                regwrite_raw = 1'b1;
            end
            S_BEQEX, S_BNEEX: begin
                ctrl.alusrca    = 1'b1;
                ctrl.alucontrol = ALU_SUB;
                ctrl.pcsrc      = 2'b01;
                branch_eq       = (state_q == S_BEQEX);
                branch_ne       = (state_q == S_BNEEX);
            end
            S_IMMEX: begin
                ctrl.alusrca        = 1'b1;
                ctrl.alusrcb        = 2'b10;
                ctrl.res_zeroextimm = (op_q == OP_ANDI || op_q == OP_ORI);
                if (op_q == OP_ANDI)     ctrl.alucontrol = ALU_AND;
                else if (op_q == OP_ORI) ctrl.alucontrol = ALU_OR;
                else                     ctrl.alucontrol = ALU_ADD;
            end
            S_IMMWB: begin
                regwrite_raw        = 1'b1;
                ctrl.res_zeroextimm = (op_q == OP_ANDI || op_q == OP_ORI);
            end
            S_JEX: begin
                ctrl.pcsrc = 2'b10;
                pcwrite    = 1'b1;
            end
            default: begin
                pcwrite = 1'b0;
            end
        endcase
    end

    // Architectural strobes are suppressed in any reset cycle so an aborted instruction leaves no trace.
    assign ctrl.pcen     = ~reset & (pcwrite | (branch_eq & ctrl.zero) | (branch_ne & ~ctrl.zero));
    assign ctrl.irwrite  = ~reset & irwrite_raw;
    assign ctrl.regwrite = ~reset & regwrite_raw;
    assign ctrl.memwrite = ~reset & memwrite_raw;
    assign ctrl.state    = 4'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: stimulus queues expected per-cycle
// state/control vectors, a negedge monitor pops and compares them.
module tb_multicycle_controller;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_LB   = 6'b100000;
    localparam logic [5:0] OP_SB   = 6'b101000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ILL  = 6'b111111;
    localparam logic [5:0] F_SUB   = 6'b100010;

    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0110;
    localparam logic [3:0] ORR = 4'b0001;

    logic clk;
    logic reset;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    string       name_q[$];
    logic [21:0] exp_q[$];

    // Packs control fields into the order the monitor observes them.
    function automatic logic [17:0] mk(
        input logic pcen, input logic irw, input logic iord, input logic mw,
        input logic be, input logic rw, input logic rd, input logic m2r,
        input logic asa, input logic [1:0] asb, input logic [1:0] pcs,
        input logic [3:0] alu, input logic rzx);
        return {pcen, irw, iord, mw, be, rw, rd, m2r, asa, asb, pcs, alu, rzx};
    endfunction

    // Queue the expectation for the current cycle, then advance to just after the next edge.
    task automatic cyc(input string nm, input logic [3:0] st, input logic [17:0] ctl);
        name_q.push_back(nm);
        exp_q.push_back({st, ctl});
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the DUT outputs mid-cycle against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [21:0] got;
            logic [21:0] exp;
            string       nm;
            got = {bus.state, bus.pcen, bus.irwrite, bus.iord, bus.memwrite, bus.byte_enable,
                   bus.regwrite, bus.regdst, bus.memtoreg, bus.alusrca, bus.alusrcb,
                   bus.pcsrc, bus.alucontrol, bus.res_zeroextimm};
            exp = exp_q.pop_front();
            nm  = name_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL %s: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                         nm, got[21:18], got[17:0], exp[21:18], exp[17:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] v_fetch, v_fetch_off, v_dec;
        v_fetch     = mk(1,1,0,0,0,0,0,0,0,2'b01,2'b00,ADD,0);
        v_fetch_off = mk(0,0,0,0,0,0,0,0,0,2'b01,2'b00,ADD,0);
        v_dec       = mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,ADD,0);

        reset = 1'b1; bus.memready = 1'b1; bus.op = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0;
        @(posedge clk); #1;
        cyc("reset_a", 4'd0, v_fetch_off);
        cyc("reset_b", 4'd0, v_fetch_off);

        // R-type sub; op/funct scrambled after DECODE must not matter
        reset = 1'b0; bus.op = OP_R; bus.funct = F_SUB;
        cyc("r_fetch", 4'd0, v_fetch);
        cyc("r_decode", 4'd1, v_dec);
        bus.op = OP_ILL; bus.funct = 6'd0;
        cyc("r_ex", 4'd6, mk(0,0,0,0,0,0,0,0,1,2'b00,2'b00,SUB,0));
        cyc("r_wb", 4'd7, mk(0,0,0,0,0,1,1,0,0,2'b00,2'b00,ADD,0));

        // lb with three stall cycles in MEMRD
        bus.op = OP_LB;
        cyc("lb_fetch", 4'd0, v_fetch);
        cyc("lb_decode", 4'd1, v_dec);
        cyc("lb_memadr", 4'd2, mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,ADD,0));
        bus.memready = 1'b0;
        for (int i = 0; i < 3; i++)
            cyc("lb_memrd_stall", 4'd3, mk(0,0,1,0,1,0,0,0,0,2'b00,2'b00,ADD,0));
        bus.memready = 1'b1;
        cyc("lb_memrd_done", 4'd3, mk(0,0,1,0,1,0,0,0,0,2'b00,2'b00,ADD,0));
        cyc("lb_memwb", 4'd4, mk(0,0,0,0,1,1,0,1,0,2'b00,2'b00,ADD,0));

        // FETCH stall, then beq taken
        bus.memready = 1'b0; bus.op = OP_BEQ; bus.zero = 1'b1;
        cyc("fetch_stall", 4'd0, v_fetch_off);
        bus.memready = 1'b1;
        cyc("beq_fetch", 4'd0, v_fetch);
        cyc("beq_decode", 4'd1, v_dec);
        cyc("beq_ex", 4'd8, mk(1,0,0,0,0,0,0,0,1,2'b00,2'b01,SUB,0));

        // bne with zero=1 (not taken), then zero=0 (taken)
        bus.op = OP_BNE;
        cyc("bne1_fetch", 4'd0, v_fetch);
        cyc("bne1_decode", 4'd1, v_dec);
        cyc("bne_nt_ex", 4'd9, mk(0,0,0,0,0,0,0,0,1,2'b00,2'b01,SUB,0));
        bus.zero = 1'b0;
        cyc("bne2_fetch", 4'd0, v_fetch);
        cyc("bne2_decode", 4'd1, v_dec);
        cyc("bne_t_ex", 4'd9, mk(1,0,0,0,0,0,0,0,1,2'b00,2'b01,SUB,0));

        // ori
        bus.op = OP_ORI;
        cyc("ori_fetch", 4'd0, v_fetch);
        cyc("ori_decode", 4'd1, v_dec);
        cyc("ori_ex", 4'd10, mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,ORR,1));
        cyc("ori_wb", 4'd11, mk(0,0,0,0,0,1,0,0,0,2'b00,2'b00,ADD,1));

        // jump
        bus.op = OP_J;
        cyc("j_fetch", 4'd0, v_fetch);
        cyc("j_decode", 4'd1, v_dec);
        cyc("j_ex", 4'd12, mk(1,0,0,0,0,0,0,0,0,2'b00,2'b10,ADD,0));

        // illegal opcode returns straight to FETCH
        bus.op = OP_ILL;
        cyc("ill_fetch", 4'd0, v_fetch);
        cyc("ill_decode", 4'd1, v_dec);

        // sb, memory ready immediately
        bus.op = OP_SB;
        cyc("sb_fetch", 4'd0, v_fetch);
        cyc("sb_decode", 4'd1, v_dec);
        cyc("sb_memadr", 4'd2, mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,ADD,0));
        cyc("sb_memwr", 4'd5, mk(0,0,1,1,1,0,0,0,0,2'b00,2'b00,ADD,0));

        // sw aborted by reset while stalled in MEMWR
        bus.op = OP_SW;
        cyc("sw_fetch", 4'd0, v_fetch);
        cyc("sw_decode", 4'd1, v_dec);
        cyc("sw_memadr", 4'd2, mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,ADD,0));
        bus.memready = 1'b0;
        cyc("sw_memwr", 4'd5, mk(0,0,1,1,0,0,0,0,0,2'b00,2'b00,ADD,0));
        reset = 1'b1;
        cyc("sw_memwr_reset", 4'd5, mk(0,0,1,0,0,0,0,0,0,2'b00,2'b00,ADD,0));
        bus.memready = 1'b1;
        cyc("after_reset_held", 4'd0, v_fetch_off);
        reset = 1'b0;
        cyc("after_reset_fetch", 4'd0, v_fetch);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations unchecked, expected 0", exp_q.size());
        end
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore-style control FSM that sequences a multicycle MIPS datapath sharing one ALU and one unified instruction/data memory port. It is the multicycle counterpart of the single-cycle `controller`. It decodes `op`/`funct` and walks each instruction through fetch, decode, execute, memory and writeback states. It stalls on a memory-ready handshake and drives every datapath select and write strobe, including `byte_enable` for lb/sb and `res_zeroextimm` for andi/ori.

## Interface
- No parameters; all encodings fixed below.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 6: instr[31:26]; sampled only in DECODE.
- `funct` in 6: instr[5:0]; sampled only in DECODE.
- `zero` in 1: ALU zero flag.
- `memready` in 1: memory completes the current access this cycle.
- `pcen` out 1: PC write enable = pcwrite | (beq & zero) | (bne & ~zero).
- `irwrite` out 1: instruction register load.
- `iord` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `memwrite` out 1: memory write strobe.
- `byte_enable` out 1: byte access for lb/sb.
- `regwrite` out 1: register file write.
- `regdst` out 1: write-register select; 1 = rd, 0 = rt.
- `memtoreg` out 1: writeback select; 1 = MDR, 0 = ALUOut.
- `alusrca` out 1: ALU A select; 0 = PC, 1 = regA.
- `alusrcb` out 2: ALU B select; 00 = regB, 01 = 4, 10 = extimm, 11 = extimm<<2.
- `pcsrc` out 2: PC source; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alucontrol` out 4: ALU operation; 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
- `res_zeroextimm` out 1: zero-extend the immediate when set, sign-extend otherwise.
- `state` out 4: current state, for debug.

## Operation
- Opcodes: R 000000, lw 100011, sw 101011, lb 100000, sb 101000, beq 000100, bne 000101, addi 001000, andi 001100, ori 001101, j 000010.
- R-type funct codes: add 100000, sub 100010, and 100100, or 100101, slt 101010, nor 100111.
- `op`/`funct` are latched into internal registers on DECODE exit. All later states use only the latched copies.
- Unless listed for a state, every output is 0 and alucontrol = ADD.
- States, with encoding and outputs:
  - FETCH (0): alusrcb=01. irwrite = pcwrite = memready. Stays in FETCH while !memready; goes to DECODE when memready.
  - DECODE (1): alusrcb=11, forming the branch target. Next state by op:
    - lw/lb/sw/sb → MEMADR
    - R-type with legal funct → RTYPEEX
    - beq → BEQEX; bne → BNEEX
    - addi/andi/ori → IMMEX
    - j → JEX
    - illegal op or illegal funct → FETCH, with no architectural effect.
  - MEMADR (2): alusrca=1, alusrcb=10. Goes to MEMRD for lw/lb, MEMWR for sw/sb.
  - MEMRD (3): iord=1; byte_enable=1 for lb. Waits for memready, then goes to MEMWB.
  - MEMWB (4): memtoreg=1, regwrite=1; byte_enable=1 for lb. Goes to FETCH.
  - MEMWR (5): iord=1, memwrite=1 on every cycle in the state; byte_enable=1 for sb. Waits for memready, then goes to FETCH.
  - RTYPEEX (6): alusrca=1, alucontrol from funct. Goes to RTYPEWB.
  - RTYPEWB (7): regdst=1, regwrite=1. Goes to FETCH.
  - BEQEX (8) / BNEEX (9): alusrca=1, alucontrol=SUB, pcsrc=01; branch condition drives pcen as above. Goes to FETCH.
  - IMMEX (10): alusrca=1, alusrcb=10. alucontrol is ADD for addi, AND for andi, OR for ori. res_zeroextimm=1 for andi/ori. Goes to IMMWB.
  - IMMWB (11): regwrite=1; res_zeroextimm is held as in IMMEX. Goes to FETCH.
  - JEX (12): pcsrc=10, pcwrite=1. Goes to FETCH.
- State encodings 13–15 are unreachable; if ever entered, the FSM goes to FETCH with all strobes 0.

## Timing
- `state` is registered. All outputs are combinational from `state`, the latched op/funct, `zero` and `memready`. There is no output register.
- Reset: on a clock edge with reset=1, state becomes FETCH and the latched op/funct are cleared. While reset=1, pcen, irwrite, regwrite and memwrite are forced to 0 in the same cycle.
- Reset asserted mid-instruction aborts that instruction. No partial register or memory write occurs in the reset cycle.
- Cycles per instruction with memready held at 1:
  - lw/lb: 5
  - sw/sb, R-type, addi/andi/ori: 4
  - beq/bne, j: 3
  - illegal: 2
- Each cycle with memready=0 in FETCH, MEMRD or MEMWR adds one cycle. Outputs hold steady throughout the stall.
- memready is ignored in all other states.
- `op`/`funct` changes after DECODE have no effect on the instruction in progress.

## Test plan
- Reset: reset=1 for 2 cycles with memready=1 → state=0. During reset pcen=irwrite=regwrite=memwrite=0. The first cycle after reset drops shows irwrite=1, pcen=1, alusrcb=01, alucontrol=0010.
- R-type sub (funct 100010), memready=1 → state sequence 0,1,6,7,0. RTYPEEX drives alucontrol=0110. RTYPEWB drives regdst=1, regwrite=1, memtoreg=0.
- lb with memready=0 for 3 cycles in MEMRD → sequence 0,1,2,3,3,3,3,4,0. byte_enable=1 and iord=1 throughout MEMRD. MEMWB drives memtoreg=1, regwrite=1.
- beq with zero=1, then bne with zero=1 → beq gives pcen=1, pcsrc=01 in state 8. bne gives pcen=0 in state 9.
- ori (001101) → IMMEX drives alucontrol=0001, res_zeroextimm=1. IMMWB drives regwrite=1, regdst=0.
- Illegal op 111111 → sequence 0,1,0 with no write strobes. Separately, reset asserted during MEMWR gives memwrite=0 that cycle and state=0 on the next cycle.
